mult2_accumulator: RTL and testbench

MULT2_ACCUMULATOR -- requirements
Module: mult2_accumulator

---
 rtl/mult2_accumulator_pkg.sv | 17 +
 rtl/mult2_accumulator_sat_adder.sv | 26 ++
 rtl/mult2_accumulator.sv | 123 ++++++++++++
 tb/tb_mult2_accumulator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult2_accumulator_pkg.sv
// rtl/mult2_accumulator_pkg.sv - shared types and constants for the product accumulator
// Purpose: FSM state encoding and widths shared by mult2_accumulator and sat_adder.
// Ports:   none (package).

package mult2_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int PROD_W    = 4;
  localparam int MAX_COUNT = 255;
  localparam int CNT_W     = 8;

endpackage

// File: rtl/mult2_accumulator_sat_adder.sv
// rtl/mult2_accumulator_sat_adder.sv - saturating add of a zero-extended product to the accumulator
// Purpose: a + zext(b), clamped to all-ones when the true sum does not fit in ACC_W bits.
// Ports:   a        - ACC_W-bit accumulator operand
//          b        - PROD_W-bit product operand (zero-extended)
//          sum      - clamped ACC_W-bit result
//          overflow - 1 when the unclamped sum exceeded 2^ACC_W-1

module sat_adder
  import mult2_accumulator_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              overflow
);

  // One extra bit catches the carry; ACC_W >= PROD_W so the pad width is never negative.
  logic [ACC_W:0] raw;

  assign raw      = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
  assign overflow = raw[ACC_W];
  assign sum      = overflow ? {ACC_W{1'b1}} : raw[ACC_W-1:0];

endmodule

// File: rtl/mult2_accumulator.sv
// rtl/mult2_accumulator.sv - batch accumulator of 4-bit products with saturation and result hold
// Purpose: after start, accept COUNT products, sum them with saturation, then hold the
//          result until the consumer takes it.
// Ports:   clk, rst_n           - clock, asynchronous active-low reset
//          start, clr           - begin a batch / abort to IDLE (clr wins)
//          prod, in_valid       - product input stream, in_ready when in ACC
//          sum, sat, out_valid  - registered result, valid in HOLD
//          out_ready            - consumer handshake
//          busy                 - state is not IDLE

module mult2_accumulator
  import mult2_accumulator_pkg::*;
#(
  parameter int COUNT = 4,
  parameter int ACC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clr,
  input  logic [PROD_W-1:0] prod,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  sum,
  output logic              sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  // cnt value at which the next accept is the final one of the batch.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               sat_q, sat_nxt;

  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;

  sat_adder #(
    .ACC_W (ACC_W)
  ) u_sat_adder (
    .a        (acc),
    .b        (prod),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      sat_q <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      sat_q <= sat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    sat_nxt   = sat_q;

    if (clr) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      sat_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = ACC;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            sat_nxt   = 1'b0;
          end
        end
        ACC: begin
          // in_ready is 1 throughout ACC, so in_valid alone marks an accept.
          if (in_valid) begin
            acc_nxt = add_sum;
            cnt_nxt = cnt + 1'b1;
            sat_nxt = sat_q | add_ovf;
            if (cnt == LAST_CNT) begin
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (start) begin
              // Back-to-back: skip IDLE and start the next batch cleanly.
              state_nxt = ACC;
              acc_nxt   = '0;
              cnt_nxt   = '0;
              sat_nxt   = 1'b0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign sum       = acc;
  assign sat       = sat_q;

endmodule

// File: tb/tb_mult2_accumulator.sv
// tb/tb_mult2_accumulator.sv - randomized self-checking bench for mult2_accumulator

module tb_mult2_accumulator;

  localparam int COUNT  = 4;
  localparam int ACC_W  = 8;
  localparam int MAXV   = (1 << ACC_W) - 1;
  localparam int COUNT2 = 40;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start, clr, in_valid, out_ready;
  logic [3:0]       prod;
  logic             in_ready, sat, out_valid, busy;
  logic [ACC_W-1:0] sum;

  logic             start2, clr2, in_valid2, out_ready2;
  logic [3:0]       prod2;
  logic             in_ready2, sat2, out_valid2, busy2;
  logic [7:0]       sum2;

  int checks = 0;
  int errors = 0;
  int prod_q[$];
  bit valid_q[$];

  always #5 clk = ~clk;

  mult2_accumulator #(.COUNT(COUNT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .prod(prod),
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  mult2_accumulator #(.COUNT(COUNT2), .ACC_W(8)) dut40 (
    .clk(clk), .rst_n(rst_n), .start(start2), .clr(clr2), .prod(prod2),
    .in_valid(in_valid2), .in_ready(in_ready2), .sum(sum2), .sat(sat2),
    .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the batch result is the plain sum of accepted products clamped to MAXV.
  function automatic int model_sum(input int total, input int maxv);
    return (total > maxv) ? maxv : total;
  endfunction

  task automatic run_batch(input bit skip_start, input bit rand_valid,
                           input int hold_wait, input bit chain);
    int accepts = 0;
    int total   = 0;
    int cycles  = 0;
    int exp_sum;
    bit v;
    int p;
    if (!skip_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("busy_acc", busy, 1);
    check("in_ready_acc", in_ready, 1);
    while (accepts < COUNT && cycles < 200) begin
      if (valid_q.size() > 0) v = valid_q.pop_front();
      else                    v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v && prod_q.size() > 0) p = prod_q.pop_front();
      else                        p = $urandom_range(0, 15);
      in_valid = v;
      prod     = p[3:0];
      start    = 1'($urandom_range(0, 1));
      tick();
      cycles++;
      if (v) begin
        accepts++;
        total += p;
      end
      check("out_valid_latency", out_valid, accepts == COUNT);
      if (accepts < COUNT) check("in_ready_acc", in_ready, 1);
    end
    check("batch_accepts", accepts, COUNT);
    in_valid = 1'b0;
    start    = 1'b0;
    exp_sum  = model_sum(total, MAXV);
    check("sum", sum, exp_sum);
    check("sat", sat, total > MAXV);
    for (int i = 0; i < hold_wait; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      prod      = 4'($urandom);
      start     = 1'($urandom_range(0, 1));
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", sum, exp_sum);
      check("hold_sat", sat, total > MAXV);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = chain;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_busy", busy, chain);
    if (chain) check("chain_cleared", sum, 0);
  endtask

  initial begin
    bit chained;
    bit c;
    int total2;
    start = 0; clr = 0; in_valid = 0; out_ready = 0; prod = 0;
    start2 = 0; clr2 = 0; in_valid2 = 0; out_ready2 = 0; prod2 = 0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_sum", sum, 0);
    check("rst_sat", sat, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Scenario 1: basic batch, immediate handshake.
    prod_q = '{1, 4, 9, 6};
    run_batch(1'b0, 1'b0, 0, 1'b0);

    // Scenario 3: stalls and a held result.
    prod_q  = '{2, 2, 2, 2};
    valid_q = '{1, 0, 0, 1, 1, 0, 1};
    run_batch(1'b0, 1'b0, 5, 1'b0);

    // Scenario 4: back-to-back batches.
    prod_q = '{5, 0, 15, 7};
    run_batch(1'b0, 1'b0, 1, 1'b1);
    prod_q = '{3, 3, 3, 3};
    run_batch(1'b1, 1'b0, 2, 1'b0);

    // Scenario 5: clr after two accepts, racing a start.
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; prod = 4'd7; tick();
    prod = 4'd5; tick();
    in_valid = 1'b0; clr = 1'b1; start = 1'b1; tick();
    clr = 1'b0; start = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_sum", sum, 0);
    check("clr_sat", sat, 0);
    prod_q = '{1, 1, 1, 1};
    run_batch(1'b0, 1'b0, 1, 1'b0);

    // Scenario 6: asynchronous reset while holding a result.
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; prod = 4'd3;
    repeat (COUNT) tick();
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_sum", sum, 12);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_in_ready", in_ready, 0);
    check("async_rst_sum", sum, 0);
    check("async_rst_sat", sat, 0);
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_held_valid", out_valid, 0);
    end
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("first_start_honoured", busy, 1);
    run_batch(1'b1, 1'b1, 1, 1'b0);

    // Randomized batches with random stalls, hold times and chaining.
    chained = 1'b0;
    for (int b = 0; b < 25; b++) begin
      c = 1'($urandom_range(0, 1));
      run_batch(chained, 1'b1, $urandom_range(0, 3), c);
      chained = c;
    end
    if (chained) run_batch(1'b1, 1'b1, 0, 1'b0);

    // Scenario 2: saturation with COUNT=40.
    total2 = 0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    in_valid2 = 1'b1; prod2 = 4'd9;
    for (int i = 0; i < COUNT2; i++) begin
      tick();
      total2 += 9;
      check("sat40_out_valid", out_valid2, (i == COUNT2 - 1));
    end
    in_valid2 = 1'b0;
    check("sat40_sum", sum2, model_sum(total2, 255));
    check("sat40_sat", sat2, total2 > 255);
    out_ready2 = 1'b1; tick(); out_ready2 = 1'b0;
    check("sat40_post_hs", out_valid2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
